// File: rtl/tournament_selector.sv
// Parent selection: four LFSR-drawn population reads feed two binary
// tournaments whose winners are held as a dad/mom pair on valid/ready.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ce               clock enable for read issue and LFSR advance
//   rd_en, rd_addr   population RAM read strobe and address
//   rd_individual    RAM individual data, one cycle after rd_en
//   rd_fitness       RAM fitness data, one cycle after rd_en
//   dad, mom         tournament-0 and tournament-1 winners
//   valid, ready     output pair handshake
module tournament_selector #(
  parameter int          IndividualWidth = 32,
  parameter int          FitnessWidth    = 16,
  parameter int          PopulationSize  = 16,
  parameter int          AddrWidth       = $clog2(PopulationSize),
  parameter logic [15:0] Seed            = 16'h0001
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  output logic                       rd_en,
  output logic [AddrWidth-1:0]       rd_addr,
  input  logic [IndividualWidth-1:0] rd_individual,
  input  logic [FitnessWidth-1:0]    rd_fitness,
  output logic [IndividualWidth-1:0] dad,
  output logic [IndividualWidth-1:0] mom,
  output logic                       valid,
  input  logic                       ready
);

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [15:0] SeedEff =
    (Seed == 16'h0000) ? 16'h0001 : Seed;

  typedef enum logic {
    FETCH,
    OUT
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [15:0]                lfsr;
  logic [15:0]                lfsr_next;
  logic [2:0]                 issued;
  logic [2:0]                 received;
  logic                       pending;
  logic                       last_cap;
  logic                       xfer;
  logic [IndividualWidth-1:0] slot_ind [4];
  logic [FitnessWidth-1:0]    slot_fit [4];

  assign lfsr_next = {lfsr[14:0],
                      lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign rd_addr   = lfsr[AddrWidth-1:0];
  assign last_cap  = pending && (received == 3'd3);
  assign xfer      = valid && ready;

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    unique case (state)
      FETCH: begin
        rd_en = ce && (issued < 3'd4) && !rst;
        if (last_cap) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (xfer) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      lfsr     <= SeedEff;
      issued   <= 3'd0;
      received <= 3'd0;
      pending  <= 1'b0;
      dad      <= '0;
      mom      <= '0;
      valid    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        slot_ind[i] <= '0;
        slot_fit[i] <= '0;
      end
    end else begin
      state   <= state_next;
      pending <= rd_en;
      if (rd_en) begin
        lfsr   <= lfsr_next;
        issued <= issued + 3'd1;
      end
      // Capture ignores ce so an in-flight read always lands.
      if (pending) begin
        slot_ind[received[1:0]] <= rd_individual;
        slot_fit[received[1:0]] <= rd_fitness;
        received                <= received + 3'd1;
      end
      // Strict '>' keeps the earlier draw on a tie; slot 3 is
      // taken straight from the RAM bus as it is still landing.
      if (last_cap) begin
        dad   <= (slot_fit[1] > slot_fit[0]) ?
                 slot_ind[1] : slot_ind[0];
        mom   <= (rd_fitness > slot_fit[2]) ?
                 rd_individual : slot_ind[2];
        valid <= 1'b1;
      end
      if ((state == OUT) && xfer) begin
        valid    <= 1'b0;
        issued   <= 3'd0;
        received <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_tournament_selector.sv
// Directed bench for tournament_selector with a draw-level reference
// model; a second instance with Seed=0 must track the Seed=1 model.
module tb_tournament_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        ready;

  logic        a_rd_en, b_rd_en;
  logic [3:0]  a_rd_addr, b_rd_addr;
  logic [31:0] a_ind, b_ind;
  logic [15:0] a_fit, b_fit;
  logic [31:0] a_dad, a_mom, b_dad, b_mom;
  logic        a_valid, b_valid;

  logic [31:0] ind_mem [16];
  logic [15:0] fit_mem [16];

  int checks = 0;
  int errors = 0;

  logic [3:0] addr_log [$];

  always #5 clk = ~clk;

  tournament_selector #(
    .IndividualWidth(32), .FitnessWidth(16),
    .PopulationSize(16), .AddrWidth(4), .Seed(16'h0001)
  ) dut_a (
    .clk(clk), .rst(rst), .ce(ce),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_individual(a_ind), .rd_fitness(a_fit),
    .dad(a_dad), .mom(a_mom), .valid(a_valid), .ready(ready)
  );

  tournament_selector #(
    .IndividualWidth(32), .FitnessWidth(16),
    .PopulationSize(16), .AddrWidth(4), .Seed(16'h0000)
  ) dut_b (
    .clk(clk), .rst(rst), .ce(ce),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_individual(b_ind), .rd_fitness(b_fit),
    .dad(b_dad), .mom(b_mom), .valid(b_valid), .ready(ready)
  );

  // Synchronous population RAMs, one per instance.
  always @(posedge clk) begin
    if (a_rd_en) begin
      a_ind <= ind_mem[a_rd_addr];
      a_fit <= fit_mem[a_rd_addr];
    end
    if (b_rd_en) begin
      b_ind <= ind_mem[b_rd_addr];
      b_fit <= fit_mem[b_rd_addr];
    end
  end

  // Reference model: a list of drawn indices, a count of arrived
  // responses, and the tournament result computed from the memory.
  logic [15:0] m_lfsr;
  int          m_issued;
  int          m_arrive;
  bit          m_last;
  bit          m_hold;
  logic [31:0] m_dad, m_mom;
  logic [3:0]  draws [4];
  logic        exp_rd_en;

  function automatic logic [31:0] pick(logic [3:0] a, logic [3:0] b);
    return (fit_mem[b] > fit_mem[a]) ? ind_mem[b] : ind_mem[a];
  endfunction

  function automatic logic [15:0] step(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  assign exp_rd_en = !rst && ce && !m_hold && (m_issued < 4);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr   <= 16'h0001;
      m_issued <= 0;
      m_arrive <= 0;
      m_last   <= 1'b0;
      m_hold   <= 1'b0;
      m_dad    <= '0;
      m_mom    <= '0;
    end else if (m_hold) begin
      if (ready) begin
        m_hold   <= 1'b0;
        m_issued <= 0;
        m_arrive <= 0;
      end
    end else begin
      m_last <= exp_rd_en;
      if (exp_rd_en) begin
        draws[m_issued] <= m_lfsr[3:0];
        m_lfsr          <= step(m_lfsr);
        m_issued        <= m_issued + 1;
      end
      if (m_last) begin
        m_arrive <= m_arrive + 1;
        if (m_arrive == 3) begin
          m_hold <= 1'b1;
          m_dad  <= pick(draws[0], draws[1]);
          m_mom  <= pick(draws[2], draws[3]);
        end
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("a_rd_en", 64'(a_rd_en), 64'(exp_rd_en));
    chk("b_rd_en", 64'(b_rd_en), 64'(exp_rd_en));
    chk("a_valid", 64'(a_valid), 64'(m_hold));
    chk("b_valid", 64'(b_valid), 64'(m_hold));
    if (exp_rd_en) begin
      chk("a_rd_addr", 64'(a_rd_addr), 64'(m_lfsr[3:0]));
      chk("b_rd_addr", 64'(b_rd_addr), 64'(m_lfsr[3:0]));
      addr_log.push_back(a_rd_addr);
    end
    if (m_hold) begin
      chk("a_dad", 64'(a_dad), 64'(m_dad));
      chk("a_mom", 64'(a_mom), 64'(m_mom));
      chk("b_dad", 64'(b_dad), 64'(m_dad));
      chk("b_mom", 64'(b_mom), 64'(m_mom));
    end
  end

  function automatic logic [19:0] packed_log();
    if (addr_log.size() != 4) return 20'hFFFFF;
    return {4'h4, addr_log[3], addr_log[2], addr_log[1], addr_log[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then release with ce=1; the caller is then in cycle c0.
  task automatic start();
    rst = 1'b1;
    tick();
    tick();
    addr_log.delete();
    rst = 1'b0;
    ce  = 1'b1;
  endtask

  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (a_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic load(input bit flat);
    for (int i = 0; i < 16; i++) begin
      ind_mem[i] = 32'hA000_0000 + 32'(i);
      fit_mem[i] = flat ? 16'h0050 : 16'(i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst   = 1'b1;
    ce    = 1'b0;
    ready = 1'b1;
    load(1'b0);

    // Reset state.
    tick();
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_rd_en", 64'(a_rd_en), 64'd0);
    chk("rst_dad", 64'(a_dad), 64'd0);

    // Scenario 1: increasing fitness; seed 0 instance matches.
    start();
    chk("s1_b_first_addr", 64'(b_rd_addr), 64'd1);
    wait_valid(0, n);
    chk("s1_latency", 64'(n), 64'd5);
    chk("s1_dad", 64'(a_dad), 64'hA000_0002);
    chk("s1_mom", 64'(a_mom), 64'hA000_0008);
    chk("s1_model_dad", 64'(m_dad), 64'hA000_0002);
    chk("s1_model_mom", 64'(m_mom), 64'hA000_0008);
    chk("s1_b_dad", 64'(b_dad), 64'hA000_0002);
    chk("s1_addrs", 64'(packed_log()), 64'h4_8421);

    // Scenario 2: all fitness equal, earlier draw wins.
    load(1'b1);
    start();
    wait_valid(0, n);
    chk("s2_latency", 64'(n), 64'd5);
    chk("s2_dad", 64'(a_dad), 64'hA000_0001);
    chk("s2_mom", 64'(a_mom), 64'hA000_0004);

    // Scenario 3: backpressure, then a second tournament.
    load(1'b0);
    ready = 1'b0;
    start();
    wait_valid(0, n);
    chk("s3_latency", 64'(n), 64'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s3_hold_valid", 64'(a_valid), 64'd1);
      chk("s3_hold_rd_en", 64'(a_rd_en), 64'd0);
      chk("s3_hold_dad", 64'(a_dad), 64'hA000_0002);
      chk("s3_hold_mom", 64'(a_mom), 64'hA000_0008);
    end
    addr_log.delete();
    ready = 1'b1;
    tick();
    chk("s3_drop_valid", 64'(a_valid), 64'd0);
    chk("s3_reissue", 64'(a_rd_en), 64'd1);
    chk("s3_addr0", 64'(a_rd_addr), 64'd0);
    wait_valid(0, n);
    chk("s3_latency2", 64'(n), 64'd5);
    chk("s3_dad2", 64'(a_dad), 64'hA000_0000);
    chk("s3_mom2", 64'(a_mom), 64'hA000_0000);
    chk("s3_addrs2", 64'(packed_log()), 64'h4_0000);

    // Scenario 4: ce low for three cycles after the second issue.
    start();
    tick();
    tick();
    ce = 1'b0;
    tick();
    tick();
    tick();
    ce = 1'b1;
    wait_valid(5, n);
    chk("s4_latency", 64'(n), 64'd8);
    chk("s4_dad", 64'(a_dad), 64'hA000_0002);
    chk("s4_mom", 64'(a_mom), 64'hA000_0008);

    // Scenario 5: reset pulse in c2 restarts from the seed.
    start();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("s5_rst_rd_en", 64'(a_rd_en), 64'd0);
    chk("s5_rst_valid", 64'(a_valid), 64'd0);
    tick();
    chk("s5_rst_rd_en2", 64'(a_rd_en), 64'd0);
    addr_log.delete();
    rst = 1'b0;
    chk("s5_restart_addr", 64'(a_rd_addr), 64'd1);
    wait_valid(0, n);
    chk("s5_latency", 64'(n), 64'd5);
    chk("s5_dad", 64'(a_dad), 64'hA000_0002);
    chk("s5_mom", 64'(a_mom), 64'hA000_0008);
    chk("s5_addrs", 64'(packed_log()), 64'h4_8421);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
